// File: rtl/noc_link_pkg.sv
// noc_link_pkg: shared constants and helpers for the inter-FPGA NoC link adapter.
// Contents: default flit width, flit/link-word field offsets, constant clog2.
// Field layout of a link word: {valid, ch_id[CH_W-1:0], payload[FLIT_W-2:0]}.
package noc_link_pkg;

  localparam int FLIT_W_DEF = 17;

  // Constant-safe ceil(log2(n)); returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Valid bit of a router flit.
  function automatic int flit_valid_bit(input int flit_w);
    return flit_w - 1;
  endfunction

  // Link-word field offsets.
  function automatic int link_valid_bit(input int flit_w, input int ch_w);
    return flit_w + ch_w - 1;
  endfunction

  function automatic int link_ch_lsb(input int flit_w);
    return flit_w - 1;
  endfunction

  function automatic int link_payload_msb(input int flit_w);
    return flit_w - 2;
  endfunction

endpackage

// File: rtl/noc_link_mux_fifo.sv
// link_chan_fifo: one per-channel TX FIFO holding flit payloads (valid bit stripped).
// Latency: write visible at rd_data the cycle after the write edge; no bypass.
// Backpressure: full flag from the registered occupancy; a write on full is accepted only with a same-cycle read.
// Ports: clk, rst_n (sync, active-low); wr_en/wr_data; rd_en/rd_data (head, combinational); empty, full.
module link_chan_fifo
  import noc_link_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = FLIT_W_DEF - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full
);

  localparam int AW = clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_rd;
  logic          do_wr;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rd_data = mem[rd_ptr];

  assign do_rd = rd_en & ~empty;
  // A full FIFO still takes a write when its head leaves in the same cycle.
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_link_mux.sv
// noc_link_mux: buffers NUM_CH router link flits and round-robins them onto one tagged link word; demuxes received words.
// Latency: TX ch_in -> link_tx 2 cycles (empty FIFO, winning arbitration); RX link_rx -> ch_out 1 cycle.
// Backpressure: none upstream; valid flits hitting a full, non-draining FIFO are dropped and flagged in sticky ch_ovf.
// Ports: clk, rst_n (sync, active-low); ch_in/ch_out packed NUM_CH x FLIT_W; ch_full, ch_ovf per channel;
//        link_tx/link_rx {valid, ch_id, payload}; rx_err sticky out-of-range ch_id on receive.
module noc_link_mux
  import noc_link_pkg::*;
#(
  parameter int NUM_CH = 10,
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = 4,
  parameter int CH_W   = clog2(NUM_CH),
  parameter int LINK_W = FLIT_W + CH_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*FLIT_W-1:0] ch_in,
  output logic [NUM_CH*FLIT_W-1:0] ch_out,
  output logic [NUM_CH-1:0]        ch_full,
  output logic [NUM_CH-1:0]        ch_ovf,
  output logic [LINK_W-1:0]        link_tx,
  input  logic [LINK_W-1:0]        link_rx,
  output logic                     rx_err
);

  localparam int PW          = FLIT_W - 1;
  localparam int FV_BIT      = flit_valid_bit(FLIT_W);
  localparam int VALID_BIT   = link_valid_bit(FLIT_W, CH_W);
  localparam int CH_LSB      = link_ch_lsb(FLIT_W);
  localparam int PAYLOAD_MSB = link_payload_msb(FLIT_W);

  // ---------------- TX: per-channel FIFOs ----------------
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] in_vld;
  logic [NUM_CH-1:0] wr_en;
  logic [NUM_CH-1:0] rd_en;
  logic [NUM_CH-1:0] drop;
  logic [PW-1:0]     head [NUM_CH];

  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  logic [PW-1:0]     grant_pay;
  logic [CH_W-1:0]   ptr;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign in_vld[g] = ch_in[g*FLIT_W + FV_BIT];
    assign rd_en[g]  = grant_vld & (grant_ch == CH_W'(g));
    assign wr_en[g]  = in_vld[g] & (~fifo_full[g] | rd_en[g]);
    assign drop[g]   = in_vld[g] & fifo_full[g] & ~rd_en[g];

    link_chan_fifo #(
      .DEPTH (DEPTH),
      .W     (PW)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en[g]),
      .wr_data (ch_in[g*FLIT_W +: PW]),
      .rd_en   (rd_en[g]),
      .rd_data (head[g]),
      .empty   (fifo_empty[g]),
      .full    (fifo_full[g])
    );
  end

  // Occupancy is registered inside each FIFO, so this already reflects the post-edge state.
  assign ch_full = fifo_full;

  // ---------------- TX: round-robin arbiter ----------------
  // Rotating search split into two linear scans: the lowest non-empty channel at or
  // above ptr wins; otherwise the lowest non-empty channel below ptr (the wrap).
  logic            hi_vld;
  logic            lo_vld;
  logic [CH_W-1:0] hi_ch;
  logic [CH_W-1:0] lo_ch;

  always_comb begin
    hi_vld    = 1'b0;
    lo_vld    = 1'b0;
    hi_ch     = '0;
    lo_ch     = '0;
    grant_pay = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!fifo_empty[c]) begin
        if (CH_W'(c) >= ptr) begin
          if (!hi_vld) begin
            hi_vld = 1'b1;
            hi_ch  = CH_W'(c);
          end
        end else if (!lo_vld) begin
          lo_vld = 1'b1;
          lo_ch  = CH_W'(c);
        end
      end
    end
    grant_vld = hi_vld | lo_vld;
    grant_ch  = hi_vld ? hi_ch : lo_ch;
    for (int c = 0; c < NUM_CH; c++) begin
      if (CH_W'(c) == grant_ch) grant_pay = head[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      link_tx <= '0;
      ptr     <= '0;
      ch_ovf  <= '0;
    end else begin
      ch_ovf <= ch_ovf | drop;
      if (grant_vld) begin
        link_tx <= {1'b1, grant_ch, grant_pay};
        ptr     <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
      end else begin
        link_tx <= '0;
      end
    end
  end

  // ---------------- RX: register and demux ----------------
  logic                     rx_vld;
  logic [CH_W-1:0]          rx_ch;
  logic [PAYLOAD_MSB:0]     rx_pay;
  logic                     rx_bad;
  logic [NUM_CH*FLIT_W-1:0] rx_demux;

  assign rx_vld = link_rx[VALID_BIT];
  assign rx_ch  = link_rx[CH_LSB +: CH_W];
  assign rx_pay = link_rx[PAYLOAD_MSB:0];
  // Widen by one bit so the bound still works when NUM_CH is a power of two.
  assign rx_bad = rx_vld & ({1'b0, rx_ch} >= (CH_W+1)'(NUM_CH));

  // Out-of-range ids match no channel, so the demux output is all-zero for them.
  always_comb begin
    rx_demux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rx_vld && (rx_ch == CH_W'(c))) rx_demux[c*FLIT_W +: FLIT_W] = {1'b1, rx_pay};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_out <= '0;
      rx_err <= 1'b0;
    end else begin
      ch_out <= rx_demux;
      if (rx_bad) rx_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_link_mux.sv
// tb_noc_link_mux: self-checking bench for noc_link_mux (NUM_CH=10, FLIT_W=17, DEPTH=4).
// A behavioural model predicts every output each cycle; predictions are queued when
// inputs are driven and popped when the corresponding outputs are sampled.
module tb_noc_link_mux;

  localparam int NUM_CH = 10;
  localparam int FLIT_W = 17;
  localparam int DEPTH  = 4;
  localparam int CH_W   = 4;
  localparam int LINK_W = 21;
  localparam int PW     = 16;
  localparam int BUS_W  = NUM_CH * FLIT_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [BUS_W-1:0]  ch_in = '0;
  logic [BUS_W-1:0]  ch_out;
  logic [NUM_CH-1:0] ch_full;
  logic [NUM_CH-1:0] ch_ovf;
  logic [LINK_W-1:0] link_tx;
  logic [LINK_W-1:0] link_rx = '0;
  logic              rx_err;

  noc_link_mux #(
    .NUM_CH (NUM_CH),
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch_in   (ch_in),
    .ch_out  (ch_out),
    .ch_full (ch_full),
    .ch_ovf  (ch_ovf),
    .link_tx (link_tx),
    .link_rx (link_rx),
    .rx_err  (rx_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [LINK_W-1:0] link;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] ovf;
    logic [BUS_W-1:0]  chout;
    logic              rxerr;
  } exp_t;

  exp_t              sb [$];
  logic [PW-1:0]     mq [NUM_CH][$];
  int                m_ptr   = 0;
  logic [LINK_W-1:0] m_link  = '0;
  logic [NUM_CH-1:0] m_ovf   = '0;
  logic              m_rxerr = 1'b0;
  logic [BUS_W-1:0]  m_chout = '0;

  logic              loopback = 1'b0;
  logic              order_on = 1'b0;
  logic [PW-1:0]     last_pay [NUM_CH];
  logic [NUM_CH-1:0] seen = '0;

  task automatic model_step(input logic rst, input logic [BUS_W-1:0] cin, input logic [LINK_W-1:0] lrx);
    exp_t           e;
    int             win;
    int             id;
    int             sz [NUM_CH];
    logic [FLIT_W-1:0] f;
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) mq[i].delete();
      m_ptr   = 0;
      m_link  = '0;
      m_ovf   = '0;
      m_rxerr = 1'b0;
      m_chout = '0;
    end else begin
      m_chout = '0;
      if (lrx[LINK_W-1]) begin
        id = int'(lrx[LINK_W-2 -: CH_W]);
        if (id < NUM_CH) m_chout[id*FLIT_W +: FLIT_W] = {1'b1, lrx[PW-1:0]};
        else             m_rxerr = 1'b1;
      end
      win = -1;
      for (int k = 0; k < NUM_CH; k++) begin
        int j;
        j = (m_ptr + k) % NUM_CH;
        if (win < 0 && mq[j].size() > 0) win = j;
      end
      for (int i = 0; i < NUM_CH; i++) sz[i] = mq[i].size();
      if (win >= 0) begin
        m_link = {1'b1, CH_W'(win), mq[win].pop_front()};
        m_ptr  = (win + 1) % NUM_CH;
      end else begin
        m_link = '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        f = cin[i*FLIT_W +: FLIT_W];
        if (f[FLIT_W-1]) begin
          if (sz[i] < DEPTH || win == i) mq[i].push_back(f[PW-1:0]);
          else                           m_ovf[i] = 1'b1;
        end
      end
    end
    e.link  = m_link;
    e.ovf   = m_ovf;
    e.rxerr = m_rxerr;
    e.chout = m_chout;
    for (int i = 0; i < NUM_CH; i++) e.full[i] = (mq[i].size() == DEPTH);
    sb.push_back(e);
  endtask

  // Drive one cycle at the falling edge, then sample 1 time unit after the rising edge.
  // The sample taken inside call number t is therefore the DUT state of cycle t+1.
  task automatic cycle(input logic rst, input logic [BUS_W-1:0] cin, input logic [LINK_W-1:0] rx);
    exp_t e;
    int   id;
    @(negedge clk);
    rst_n   = rst;
    ch_in   = cin;
    link_rx = loopback ? link_tx : rx;
    model_step(rst, cin, loopback ? m_link : rx);
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    check("link_tx", 256'(link_tx), 256'(e.link));
    check("ch_full", 256'(ch_full), 256'(e.full));
    check("ch_ovf",  256'(ch_ovf),  256'(e.ovf));
    check("ch_out",  256'(ch_out),  256'(e.chout));
    check("rx_err",  256'(rx_err),  256'(e.rxerr));
    if (order_on && link_tx[LINK_W-1]) begin
      id = int'(link_tx[LINK_W-2 -: CH_W]);
      if (id < NUM_CH) begin
        if (seen[id]) check("ovf_order", 256'(link_tx[PW-1:0] > last_pay[id]), 256'(1));
        last_pay[id] = link_tx[PW-1:0];
        seen[id]     = 1'b1;
      end
    end
  endtask

  function automatic logic [BUS_W-1:0] one_ch(input int ch, input logic [FLIT_W-1:0] flit);
    logic [BUS_W-1:0] b;
    b = '0;
    b[ch*FLIT_W +: FLIT_W] = flit;
    return b;
  endfunction

  // Every channel valid; payload grows with t so per-channel order is observable.
  function automatic logic [BUS_W-1:0] all_vld(input int t);
    logic [BUS_W-1:0] b;
    for (int i = 0; i < NUM_CH; i++) b[i*FLIT_W +: FLIT_W] = {1'b1, PW'(t*NUM_CH + i)};
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=timeout exp=finish", cyc);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NUM_CH; i++) last_pay[i] = '0;

    // Reset state
    cycle(1'b0, '0, '0);
    cycle(1'b0, '0, '0);
    check("rst_link", 256'(link_tx), 256'(0));
    check("rst_full", 256'(ch_full), 256'(0));
    check("rst_ovf",  256'(ch_ovf),  256'(0));
    check("rst_out",  256'(ch_out),  256'(0));

    // Single flit on channel 3
    for (int t = 0; t < 6; t++) begin
      cycle(1'b1, (t == 0) ? one_ch(3, 17'h1_00A5) : '0, '0);
      if (t == 1) check("single_hit", 256'(link_tx), 256'(21'h1300A5));
      if (t == 2) check("single_gone", 256'(link_tx), 256'(0));
    end

    // Fairness: all channels once, pointer starting at 0
    cycle(1'b0, '0, '0);
    for (int t = 0; t < 14; t++) begin
      cycle(1'b1, (t == 0) ? all_vld(0) : '0, '0);
      if (t == 1)  check("fair_first", 256'(link_tx), 256'(21'h100000));
      if (t == 10) check("fair_last",  256'(link_tx), 256'(21'h190009));
      if (t == 11) check("fair_idle",  256'(link_tx), 256'(0));
    end

    // Overflow: all channels valid for 8 cycles
    cycle(1'b0, '0, '0);
    order_on = 1'b1;
    seen     = '0;
    for (int t = 0; t < 50; t++) begin
      cycle(1'b1, (t < 8) ? all_vld(t) : '0, '0);
      if (t == 2) check("full9_c3", 256'(ch_full[9]), 256'(0));
      if (t == 3) check("full9_c4", 256'(ch_full[9]), 256'(1));
      if (t == 3) check("ovf9_c4",  256'(ch_ovf[9]),  256'(0));
      if (t == 4) check("ovf9_c5",  256'(ch_ovf[9]),  256'(1));
    end
    order_on = 1'b0;

    // RX demux, then an out-of-range channel id
    cycle(1'b1, '0, 21'h171234);
    check("rx_ch7", 256'(ch_out), 256'(one_ch(7, 17'h1_1234)));
    check("rx_err_clear", 256'(rx_err), 256'(0));
    cycle(1'b1, '0, 21'h1C0000);
    check("rx_bad_out", 256'(ch_out), 256'(0));
    check("rx_bad_err", 256'(rx_err), 256'(1));
    cycle(1'b1, '0, '0);
    check("rx_err_sticky", 256'(rx_err), 256'(1));

    // Reset mid-stream with FIFOs holding flits and sticky flags set
    for (int t = 0; t < 3; t++) cycle(1'b1, all_vld(t), '0);
    cycle(1'b0, all_vld(3), '0);
    check("mid_rst_link", 256'(link_tx), 256'(0));
    check("mid_rst_full", 256'(ch_full), 256'(0));
    check("mid_rst_ovf",  256'(ch_ovf),  256'(0));
    check("mid_rst_err",  256'(rx_err),  256'(0));
    for (int t = 0; t < 4; t++) begin
      cycle(1'b1, (t == 0) ? all_vld(0) : '0, '0);
      if (t == 0) check("post_rst_idle", 256'(link_tx), 256'(0));
      if (t == 1) check("post_rst_ch0",  256'(link_tx), 256'(21'h100000));
    end

    // Loopback: link_tx fed straight back into link_rx
    cycle(1'b0, '0, '0);
    loopback = 1'b1;
    for (int t = 0; t < 6; t++) begin
      cycle(1'b1, (t == 0) ? one_ch(4, 17'h1_BEEF) : '0, '0);
      if (t == 1) check("lb_tx",  256'(link_tx), 256'(21'h14BEEF));
      if (t == 2) check("lb_out", 256'(ch_out),  256'(one_ch(4, 17'h1_BEEF)));
    end
    loopback = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
